audio_ram_datapath: RTL

//  Address and data path that works alongside the 44.1 kHz RAM sequencer (controller).

---
 rtl/audio_pkg.sv | 22 ++
 rtl/audio_mix.sv | 56 +++++
 rtl/audio_ram_datapath.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio RAM datapath
//   mode_e      : mode FSM states (IDLE, REC, PLAY, ERASE)
//   DATA_W_DEF  : default sample / RAM word width
//   ADDR_W_DEF  : default RAM word-address width
//   SAMPLE_MAX  : largest signed sample at the default width
//   SAMPLE_MIN  : smallest signed sample at the default width
package audio_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 23;

    localparam logic [DATA_W_DEF-1:0] SAMPLE_MAX = 16'h7FFF;
    localparam logic [DATA_W_DEF-1:0] SAMPLE_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REC   = 2'd1,
        PLAY  = 2'd2,
        ERASE = 2'd3
    } mode_e;

endpackage

// File: rtl/audio_mix.sv
// rtl/audio_mix.sv - registered two-input sample adder, one cycle latency
//   Build option MIX_SATURATE_EN: defined clamps the sum to the signed sample
//   range, undefined keeps the low DATA_W bits (two's-complement wrap).
//   clk_100MHz  in  system clock
//   rstn        in  asynchronous active-low reset
//   in_vld      in  add a and b on this cycle
//   a, b        in  signed samples
//   sum         out registered mixed sample
//   sum_vld     out 1-cycle strobe, sum updated
module audio_mix
    import audio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_100MHz,
    input  logic              rstn,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              sum_vld
);

    logic [DATA_W-1:0] res;

`ifdef MIX_SATURATE_EN
    logic [DATA_W:0] wide;

    assign wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};

    // Overflow shows up as the two top bits of the widened sum disagreeing;
    // the top bit then tells which rail to clamp to.
    always_comb begin
        res = wide[DATA_W-1:0];
        if (wide[DATA_W] != wide[DATA_W-1]) begin
            res = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign res = a + b;
`endif

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            sum     <= '0;
            sum_vld <= 1'b0;
        end else begin
            sum_vld <= in_vld;
            if (in_vld) begin
                sum <= res;
            end
        end
    end

endmodule

// File: rtl/audio_ram_datapath.sv
// rtl/audio_ram_datapath.sv - RAM address/data path and record/play/erase bookkeeping
//   Build option MIX_SATURATE_EN selects saturating output mix (see audio_mix).
//   clk_100MHz    in  system clock
//   rstn          in  asynchronous active-low reset
//   recording     in  record mode request (level), wins over playing
//   playing       in  play mode request (level)
//   write_zero    in  erase request (level); rising edge starts an erase
//   get_data      in  strobe: latch sample_in for a RAM write
//   data_ready    in  strobe: RAM transaction complete
//   erase_step    in  strobe: one zero word written
//   sample_in     in  live input sample
//   ram_dq_i      in  RAM read data
//   ram_addr      out RAM word address
//   ram_dq_o      out RAM write data
//   ram_dq_oe     out drive ram_dq_o onto the bus
//   audio_out     out mixed output sample
//   audio_out_vld out strobe: audio_out updated
//   rec_len       out number of recorded words
//   rec_full      out recording reached MAX_ADDR
//   erase_done    out strobe: erase finished
module audio_ram_datapath
    import audio_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              clk_100MHz,
    input  logic              rstn,
    input  logic              recording,
    input  logic              playing,
    input  logic              write_zero,
    input  logic              get_data,
    input  logic              data_ready,
    input  logic              erase_step,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] ram_dq_i,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dq_o,
    output logic              ram_dq_oe,
    output logic [DATA_W-1:0] audio_out,
    output logic              audio_out_vld,
    output logic [ADDR_W:0]   rec_len,
    output logic              rec_full,
    output logic              erase_done
);

    mode_e             state;
    mode_e             state_nxt;
    logic              busy;
    logic              wz_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dq_q;
    logic              oe_q;
    logic [ADDR_W:0]   rec_len_q;
    logic              full_q;
    logic              done_q;

    logic [ADDR_W:0]   addr_ext;
    logic [ADDR_W:0]   addr_inc;
    logic [ADDR_W:0]   last_idx;
    logic              len_zero;
    logic              at_max;
    logic              erase_fin;
    logic              rec_dr;
    logic              full_after;
    logic              rec_gd;
    logic [DATA_W-1:0] play_data;

    assign addr_ext = {1'b0, addr_q};
    assign addr_inc = addr_ext + 1'b1;
    assign last_idx = rec_len_q - 1'b1;
    assign len_zero = (rec_len_q == '0);
    assign at_max   = (addr_q == MAX_ADDR);

    assign erase_fin = (state == ERASE) && erase_step &&
                       (len_zero || (addr_ext == last_idx));

    // Completion of an outstanding write is handled before a new get_data in
    // the same cycle, so the new write must see the post-completion full flag.
    assign rec_dr     = (state == REC) && busy && data_ready;
    assign full_after = full_q | (rec_dr & at_max);
    assign rec_gd     = (state == REC) && (state_nxt == REC) && get_data && !full_after;

    always_comb begin
        state_nxt = state;
        if (!busy) begin
            if (state == ERASE) begin
                if (erase_fin || !write_zero) begin
                    state_nxt = IDLE;
                end
            end else if (write_zero && !wz_q) begin
                state_nxt = ERASE;
            end else if (recording) begin
                state_nxt = REC;
            end else if (playing) begin
                state_nxt = PLAY;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            wz_q      <= 1'b0;
            addr_q    <= '0;
            dq_q      <= '0;
            oe_q      <= 1'b0;
            rec_len_q <= '0;
            full_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            wz_q   <= write_zero;
            done_q <= 1'b0;

            if (data_ready) begin
                busy <= 1'b0;
            end

            case (state)
                REC: begin
                    if (rec_dr) begin
                        oe_q <= 1'b0;
                        if (addr_inc > rec_len_q) begin
                            rec_len_q <= addr_inc;
                        end
                        if (at_max) begin
                            full_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                    if (rec_gd) begin
                        dq_q <= sample_in;
                        oe_q <= 1'b1;
                        busy <= 1'b1;
                    end
                end
                PLAY: begin
                    if (data_ready) begin
                        if (len_zero || (addr_ext >= last_idx)) begin
                            addr_q <= '0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                ERASE: begin
                    if (erase_fin) begin
                        done_q    <= 1'b1;
                        rec_len_q <= '0;
                        full_q    <= 1'b0;
                        addr_q    <= '0;
                    end else if (erase_step && write_zero) begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: ;
            endcase

            // Any fresh entry into an active mode restarts from word 0.
            if ((state_nxt != state) && (state_nxt != IDLE)) begin
                addr_q <= '0;
            end
        end
    end

    // Only PLAY contributes read data to the mix; an empty recording plays silence.
    assign play_data = ((state == PLAY) && !len_zero) ? ram_dq_i : '0;

    audio_mix #(
        .DATA_W (DATA_W)
    ) u_mix (
        .clk_100MHz (clk_100MHz),
        .rstn       (rstn),
        .in_vld     (data_ready),
        .a          (play_data),
        .b          (sample_in),
        .sum        (audio_out),
        .sum_vld    (audio_out_vld)
    );

    // Erase drives zeros for as long as the state lasts; decoding it from the
    // state register means an abort or reset releases the bus at once.
    assign ram_addr   = addr_q;
    assign ram_dq_o   = (state == ERASE) ? '0 : dq_q;
    assign ram_dq_oe  = oe_q | (state == ERASE);
    assign rec_len    = rec_len_q;
    assign rec_full   = full_q;
    assign erase_done = done_q;

endmodule
